// File: rtl/tl_source_tracker.sv
// tl_source_tracker
// Protocol-checker front end for one TileLink-UL link. Tracks outstanding
// source IDs and counts burst beats on the A and D channels. Raises one-cycle
// registered violation strobes together with the offending source ID.
// Monitor only: every port except the outputs is sampled, nothing is driven.
//
// Ports
//   clock, reset_n         sampling clock, async active-low reset
//   a_valid/a_ready        A handshake (fire = both high)
//   a_opcode/source/size   A request fields
//   d_valid/d_ready        D handshake (fire = both high)
//   d_opcode/source/size   D response fields
//   err_dup                A first beat reused a source already in flight
//   err_orphan             D first beat used a source not in flight
//   err_beat               source/opcode/size changed mid-burst on A or D
//   err_source             source of the highest-priority strobe (0 if none)
//   inflight               one bit per outstanding source
//   busy                   OR-reduction of inflight
module tl_source_tracker #(
  parameter int unsigned SOURCE_BITS   = 4,
  parameter int unsigned SIZE_BITS     = 3,
  parameter int unsigned LG_BEAT_BYTES = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         a_valid,
  input  logic                         a_ready,
  input  logic [2:0]                   a_opcode,
  input  logic [SOURCE_BITS-1:0]       a_source,
  input  logic [SIZE_BITS-1:0]         a_size,
  input  logic                         d_valid,
  input  logic                         d_ready,
  input  logic [2:0]                   d_opcode,
  input  logic [SOURCE_BITS-1:0]       d_source,
  input  logic [SIZE_BITS-1:0]         d_size,
  output logic                         err_dup,
  output logic                         err_orphan,
  output logic                         err_beat,
  output logic [SOURCE_BITS-1:0]       err_source,
  output logic [(1<<SOURCE_BITS)-1:0]  inflight,
  output logic                         busy
);

  localparam int unsigned NUM_SRC = 1 << SOURCE_BITS;
  localparam int unsigned CW      = SIZE_BITS + 1;
  // Wide enough to hold 2^(max size) before truncation to the counter width.
  localparam int unsigned BW      = (1 << SIZE_BITS) + 1;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  // Number of beats minus one for a message of the given size.
  function automatic logic [CW-1:0] calc_beats_m1(input logic               data,
                                                  input logic [SIZE_BITS-1:0] size);
    logic [BW-1:0] beats;
    if (data && (size > SIZE_BITS'(LG_BEAT_BYTES))) begin
      beats = BW'(1) << (size - SIZE_BITS'(LG_BEAT_BYTES));
    end else begin
      beats = BW'(1);
    end
    return CW'(beats - BW'(1));
  endfunction

  // State registers.
  logic [CW-1:0]          a_cnt, a_cnt_n;
  logic [CW-1:0]          d_cnt, d_cnt_n;
  logic [2:0]             a_lat_op, a_lat_op_n;
  logic [SOURCE_BITS-1:0] a_lat_src, a_lat_src_n;
  logic [SIZE_BITS-1:0]   a_lat_size, a_lat_size_n;
  logic [CW-1:0]          a_lat_bm1, a_lat_bm1_n;
  logic [2:0]             d_lat_op, d_lat_op_n;
  logic [SOURCE_BITS-1:0] d_lat_src, d_lat_src_n;
  logic [SIZE_BITS-1:0]   d_lat_size, d_lat_size_n;
  logic [CW-1:0]          d_lat_bm1, d_lat_bm1_n;
  logic [NUM_SRC-1:0]     inflight_n;
  logic                   err_dup_n, err_orphan_n, err_beat_n;
  logic [SOURCE_BITS-1:0] err_source_n;

  // Per-beat decode.
  logic          a_fire, a_first, a_last, a_beat_err;
  logic          d_fire, d_first, d_last, d_beat_err;
  logic [CW-1:0] a_bm1, d_bm1;
  logic          d_clear_same;

  // Beat tracking on the A channel.
  always_comb begin
    a_fire       = a_valid & a_ready;
    a_first      = a_fire && (a_cnt == '0);
    a_bm1        = a_first
                   ? calc_beats_m1((a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL), a_size)
                   : a_lat_bm1;
    a_last       = a_fire && (a_cnt == a_bm1);
    a_beat_err   = a_fire && !a_first &&
                   ((a_opcode != a_lat_op) || (a_source != a_lat_src) || (a_size != a_lat_size));
    a_cnt_n      = a_cnt;
    a_lat_op_n   = a_lat_op;
    a_lat_src_n  = a_lat_src;
    a_lat_size_n = a_lat_size;
    a_lat_bm1_n  = a_lat_bm1;
    if (a_fire) begin
      a_cnt_n = a_last ? '0 : a_cnt + CW'(1);
    end
    if (a_first) begin
      a_lat_op_n   = a_opcode;
      a_lat_src_n  = a_source;
      a_lat_size_n = a_size;
      a_lat_bm1_n  = a_bm1;
    end
  end

  // Beat tracking on the D channel.
  always_comb begin
    d_fire       = d_valid & d_ready;
    d_first      = d_fire && (d_cnt == '0);
    d_bm1        = d_first ? calc_beats_m1(d_opcode == OP_ACK_DATA, d_size) : d_lat_bm1;
    d_last       = d_fire && (d_cnt == d_bm1);
    d_beat_err   = d_fire && !d_first &&
                   ((d_opcode != d_lat_op) || (d_source != d_lat_src) || (d_size != d_lat_size));
    d_cnt_n      = d_cnt;
    d_lat_op_n   = d_lat_op;
    d_lat_src_n  = d_lat_src;
    d_lat_size_n = d_lat_size;
    d_lat_bm1_n  = d_lat_bm1;
    if (d_fire) begin
      d_cnt_n = d_last ? '0 : d_cnt + CW'(1);
    end
    if (d_first) begin
      d_lat_op_n   = d_opcode;
      d_lat_src_n  = d_source;
      d_lat_size_n = d_size;
      d_lat_bm1_n  = d_bm1;
    end
  end

  // Source tracking and violation strobes. A D last beat releasing the same
  // source an A first beat claims is a legal handoff: clear, then set.
  always_comb begin
    d_clear_same = d_last && (d_source == a_source);
    inflight_n   = inflight;
    if (d_last) begin
      inflight_n[d_source] = 1'b0;
    end
    if (a_first) begin
      inflight_n[a_source] = 1'b1;
    end
    err_dup_n    = a_first && inflight[a_source] && !d_clear_same;
    err_orphan_n = d_first && !inflight[d_source];
    err_beat_n   = a_beat_err || d_beat_err;
    err_source_n = '0;
    if (err_dup_n) begin
      err_source_n = a_source;
    end else if (err_orphan_n) begin
      err_source_n = d_source;
    end else if (a_beat_err) begin
      err_source_n = a_lat_src;
    end else if (d_beat_err) begin
      err_source_n = d_lat_src;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_cnt      <= '0;
      d_cnt      <= '0;
      a_lat_op   <= '0;
      a_lat_src  <= '0;
      a_lat_size <= '0;
      a_lat_bm1  <= '0;
      d_lat_op   <= '0;
      d_lat_src  <= '0;
      d_lat_size <= '0;
      d_lat_bm1  <= '0;
      inflight   <= '0;
      busy       <= 1'b0;
      err_dup    <= 1'b0;
      err_orphan <= 1'b0;
      err_beat   <= 1'b0;
      err_source <= '0;
    end else begin
      a_cnt      <= a_cnt_n;
      d_cnt      <= d_cnt_n;
      a_lat_op   <= a_lat_op_n;
      a_lat_src  <= a_lat_src_n;
      a_lat_size <= a_lat_size_n;
      a_lat_bm1  <= a_lat_bm1_n;
      d_lat_op   <= d_lat_op_n;
      d_lat_src  <= d_lat_src_n;
      d_lat_size <= d_lat_size_n;
      d_lat_bm1  <= d_lat_bm1_n;
      inflight   <= inflight_n;
      busy       <= |inflight_n;
      err_dup    <= err_dup_n;
      err_orphan <= err_orphan_n;
      err_beat   <= err_beat_n;
      err_source <= err_source_n;
    end
  end

endmodule

// File: tb/tb_tl_source_tracker.sv
// Directed bench for tl_source_tracker with a scoreboard of expected
// post-edge output states.
module tb_tl_source_tracker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0, a_ready = 1'b0;
  logic [2:0]  a_opcode = '0;
  logic [3:0]  a_source = '0;
  logic [2:0]  a_size = '0;
  logic        d_valid = 1'b0, d_ready = 1'b0;
  logic [2:0]  d_opcode = '0;
  logic [3:0]  d_source = '0;
  logic [2:0]  d_size = '0;
  logic        err_dup, err_orphan, err_beat, busy;
  logic [3:0]  err_source;
  logic [15:0] inflight;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic        dup;
    logic        orph;
    logic        beat;
    logic        chk_src;
    logic [3:0]  src;
    logic [15:0] infl;
  } exp_t;

  exp_t sb[$];

  tl_source_tracker #(.SOURCE_BITS(4), .SIZE_BITS(3), .LG_BEAT_BYTES(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_source(a_source), .a_size(a_size),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_source(d_source), .d_size(d_size),
    .err_dup(err_dup), .err_orphan(err_orphan), .err_beat(err_beat),
    .err_source(err_source), .inflight(inflight), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_a(input logic v, input logic [2:0] op, input logic [3:0] src, input logic [2:0] sz);
    a_valid = v; a_ready = 1'b1; a_opcode = op; a_source = src; a_size = sz;
  endtask

  task automatic set_d(input logic v, input logic [2:0] op, input logic [3:0] src, input logic [2:0] sz);
    d_valid = v; d_ready = 1'b1; d_opcode = op; d_source = src; d_size = sz;
  endtask

  task automatic idle();
    a_valid = 1'b0; d_valid = 1'b0;
  endtask

  // Push expectation, clock once, pop and compare just after the edge.
  task automatic tick(input string tag, input logic dup, input logic orph, input logic beat,
                      input logic chk_src, input logic [3:0] src, input logic [15:0] infl);
    exp_t e;
    sb.push_back('{tag, dup, orph, beat, chk_src, src, infl});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".err_dup"},    32'(err_dup),    32'(e.dup));
    chk({e.tag, ".err_orphan"}, 32'(err_orphan), 32'(e.orph));
    chk({e.tag, ".err_beat"},   32'(err_beat),   32'(e.beat));
    chk({e.tag, ".inflight"},   32'(inflight),   32'(e.infl));
    chk({e.tag, ".busy"},       32'(busy),       32'(|e.infl));
    if (e.chk_src) chk({e.tag, ".err_source"}, 32'(err_source), 32'(e.src));
    @(negedge clock);
    idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".err_dup"},    32'(err_dup),    32'd0);
    chk({tag, ".err_orphan"}, 32'(err_orphan), 32'd0);
    chk({tag, ".err_beat"},   32'(err_beat),   32'd0);
    chk({tag, ".err_source"}, 32'(err_source), 32'd0);
    chk({tag, ".inflight"},   32'(inflight),   32'd0);
    chk({tag, ".busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Get src 3, ack 4 cycles later.
    set_a(1, 3'd4, 4'd3, 3'd2);
    tick("get3", 0, 0, 0, 0, 0, 16'h0008);
    for (int i = 0; i < 3; i++) tick("get3_wait", 0, 0, 0, 0, 0, 16'h0008);
    set_d(1, 3'd0, 4'd3, 3'd2);
    tick("ack3", 0, 0, 0, 0, 0, 16'h0000);

    // Valid without ready changes nothing.
    set_a(1, 3'd4, 4'd1, 3'd0); a_ready = 1'b0;
    tick("noready", 0, 0, 0, 0, 0, 16'h0000);

    // 8-beat PutFull src 5 then a duplicate first beat.
    for (int i = 0; i < 8; i++) begin
      set_a(1, 3'd0, 4'd5, 3'd6);
      tick("put5", 0, 0, 0, 0, 0, 16'h0020);
    end
    set_a(1, 3'd4, 4'd5, 3'd0);
    tick("dup5", 1, 0, 0, 1, 4'd5, 16'h0020);
    set_d(1, 3'd0, 4'd5, 3'd0);
    tick("ack5", 0, 0, 0, 0, 0, 16'h0000);

    // Orphan response.
    set_d(1, 3'd0, 4'd9, 3'd0);
    tick("orph9", 0, 1, 0, 1, 4'd9, 16'h0000);
    tick("orph9_rearm", 0, 0, 0, 0, 0, 16'h0000);

    // 4-beat AccessAckData src 2 with a corrupted beat 3.
    set_a(1, 3'd4, 4'd2, 3'd5);
    tick("get2", 0, 0, 0, 0, 0, 16'h0004);
    set_d(1, 3'd1, 4'd2, 3'd5);
    tick("d2_b1", 0, 0, 0, 0, 0, 16'h0004);
    set_d(1, 3'd1, 4'd2, 3'd5);
    tick("d2_b2", 0, 0, 0, 0, 0, 16'h0004);
    set_d(1, 3'd1, 4'd6, 3'd5);
    tick("d2_b3", 0, 0, 1, 1, 4'd2, 16'h0004);
    set_d(1, 3'd1, 4'd2, 3'd5);
    tick("d2_b4", 0, 0, 0, 0, 0, 16'h0000);

    // Same-cycle release and reclaim of src 7.
    set_a(1, 3'd4, 4'd7, 3'd0);
    tick("get7", 0, 0, 0, 0, 0, 16'h0080);
    set_a(1, 3'd4, 4'd7, 3'd0);
    set_d(1, 3'd0, 4'd7, 3'd0);
    tick("handoff7", 0, 0, 0, 0, 0, 16'h0080);
    set_d(1, 3'd0, 4'd7, 3'd0);
    tick("ack7", 0, 0, 0, 0, 0, 16'h0000);

    // Reset mid-burst, then a fresh message must be a first beat.
    set_a(1, 3'd0, 4'd1, 3'd5);
    tick("put1_b1", 0, 0, 0, 0, 0, 16'h0002);
    set_a(1, 3'd0, 4'd1, 3'd5);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clock);
    @(negedge clock);
    idle();
    reset_n = 1'b1;
    set_a(1, 3'd4, 4'd8, 3'd0);
    tick("get8_after_reset", 0, 0, 0, 1, 4'd0, 16'h0100);
    set_d(1, 3'd0, 4'd8, 3'd0);
    tick("ack8", 0, 0, 0, 0, 0, 16'h0000);

    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tl_source_tracker.md
# tl_source_tracker

Protocol-checker front end for one TileLink-UL link (A request channel, D response channel). It tracks which source IDs have an outstanding request, counts burst beats on both channels, and raises one-cycle registered violation strobes plus the offending source ID. Sits directly upstream of the per-link assertion module, which consumes the strobes and `err_source` and issues the print/fatal. Simulation/monitor use only; it never drives the link.

## Interface
Parameters:
- `SOURCE_BITS`, 4, width of source ID; tracks 2^SOURCE_BITS IDs.
- `SIZE_BITS`, 3, width of `a_size`/`d_size` (log2 bytes).
- `LG_BEAT_BYTES`, 3, log2 of data-bus bytes per beat.

Ports:
- Clock and reset: one clock (`clock`); reset is asynchronous and active-low (`reset_n`).
- `clock`  in  1  sampling clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_valid`, `a_ready`  in  1  A-channel handshake; A fires when both are 1.
- `a_opcode`  in  3  0 PutFull, 1 PutPartial (data-carrying), 4 Get.
- `a_source`  in  SOURCE_BITS  request source ID.
- `a_size`  in  SIZE_BITS  log2 transfer bytes.
- `d_valid`, `d_ready`  in  1  D-channel handshake; D fires when both are 1.
- `d_opcode`  in  3  0 AccessAck, 1 AccessAckData (data-carrying).
- `d_source`  in  SOURCE_BITS  response source ID.
- `d_size`  in  SIZE_BITS  log2 transfer bytes.
- `err_dup`  out  1  strobe: A first beat used a source already in flight.
- `err_orphan`  out  1  strobe: D first beat used a source not in flight.
- `err_beat`  out  1  strobe: source/opcode/size changed mid-burst on A or D.
- `err_source`  out  SOURCE_BITS  source of the highest-priority strobe.
- `inflight`  out  2^SOURCE_BITS  one bit per outstanding source.
- `busy`  out  1  OR-reduction of `inflight`.

## Operation
- Beats per message: data-carrying opcode and size > LG_BEAT_BYTES gives 2^(size-LG_BEAT_BYTES); otherwise 1. Counter width = SIZE_BITS+1 bits.
- Per channel, a beat counter (0 = idle/first beat). On fire: if beats==1 counter stays 0; else counter increments, returning to 0 after the last beat. First beat = fire with counter 0; last beat = fire with counter == beats-1 (or beats==1).
- On first-beat fire, latch opcode/source/size; on non-first beats compare against latch, mismatch asserts `err_beat`. Counter still advances.
- A first beat: if `inflight[a_source]` is set and not being cleared this cycle, assert `err_dup`. `inflight[a_source]` set regardless.
- D first beat: if `inflight[d_source]` is clear, assert `err_orphan`.
- D last beat: clear `inflight[d_source]`.
- Same cycle, same source, D last beat and A first beat: clear then set; final bit 1, no `err_dup`.
- `err_source` priority: dup (a_source) > orphan (d_source) > beat (A latch, then D latch).
- Non-firing cycles (valid without ready) change nothing.

## Timing
- All outputs registered; strobes assert the cycle after the offending fire, for exactly one cycle, and re-arm each cycle.
- `inflight`/`busy` reflect a fire on the following cycle.
- Reset (asserted anytime, including mid-burst): counters 0, latches 0, `inflight` 0, `busy` 0, all strobes 0, `err_source` 0. Deassertion is synchronized externally; first fire may occur on the first rising edge after release.
- No back-pressure; zero combinational paths input→output.

## Test plan
- A Get src 3 size 2 fires; D AccessAck src 3 fires 4 cycles later -> `inflight[3]`=1 cycle after A, 0 cycle after D; no strobes.
- A PutFull src 5 size 6 (8 beats) -> `inflight[5]` set after beat 1; second A first beat src 5 before any D -> `err_dup`=1 one cycle, `err_source`=5.
- D AccessAck src 9 with empty tracker -> `err_orphan`=1, `err_source`=9, `inflight` stays 0.
- D AccessAckData src 2 size 5 (4 beats), beat 3 carries src 6 -> `err_beat`=1 after beat 3, `err_source`=2; `inflight[2]` cleared after beat 4.
- Same cycle: D last beat src 7 and A Get src 7 -> `inflight[7]`=1, no `err_dup`.
- Reset_n pulsed low during beat 2 of 4-beat A burst -> all outputs 0 immediately; next A fire treated as first beat, no `err_beat`.
